// File: rtl/oven_pkg.sv
// Shared definitions for the oven controller, timer and display.
// The state encoding is fixed because other blocks decode it directly.
package oven_pkg;

    localparam int REM_W            = 10;
    localparam int DEFAULT_MAX_SECS = 999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PAUSE = 2'd1,
        ST_COOK  = 2'd2,
        ST_DONE  = 2'd3
    } oven_state_e;

    // Sums are formed one bit wider so an overflow cannot wrap before the clamp.
    function automatic logic [REM_W-1:0] clamp_secs(input logic [REM_W:0]   v,
                                                    input logic [REM_W-1:0] max_secs);
        return (v > {1'b0, max_secs}) ? max_secs : v[REM_W-1:0];
    endfunction

endpackage

// File: rtl/oven_tick_gen.sv
// One-second prescaler: counts while enabled, holds otherwise, clear wins over enable.
module oven_tick_gen #(
    parameter int CLKS_PER_SEC = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              CNT_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decoded purely from registered count and registered enable.
    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/oven_controller.sv
// Oven sequencer: cook-time setpoint, per-second countdown, heater and completion beep.
// Handshake-free: all commands are single-cycle pulses, door_open is a level.
module oven_controller
    import oven_pkg::*;
#(
    parameter int CLKS_PER_SEC = 50000000,
    parameter int MAX_SECS     = DEFAULT_MAX_SECS,
    parameter int BEEP_SECS    = 3,
    parameter int ADD_SECS     = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REM_W-1:0] time_set,
    input  logic             time_load,
    input  logic             btn_start,
    input  logic             btn_stop,
    input  logic             btn_add,
    input  logic             door_open,
    output logic [1:0]       state,
    output logic [REM_W-1:0] remaining,
    output logic             heater_on,
    output logic             done_beep,
    output logic             tick
);

    localparam int               BEEP_W = (BEEP_SECS > 0) ? $clog2(BEEP_SECS + 1) : 1;
    localparam logic [BEEP_W-1:0] BEEP_V = BEEP_W'(BEEP_SECS);
    localparam logic [REM_W-1:0]  MAX_V  = REM_W'(MAX_SECS);
    localparam logic [REM_W:0]    ADD_V  = (REM_W + 1)'(ADD_SECS);

    oven_state_e       state_q, state_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
    logic              beep_q, beep_d;
    logic              heater_q;
    logic              door_q;
    logic              presc_en;
    logic              presc_clr;
    logic              sec_tick;
    logic [REM_W-1:0]  added_secs;
    logic [REM_W-1:0]  loaded_secs;
    logic              door_rise;

    assign presc_en    = (state_q == ST_COOK) || (state_q == ST_DONE);
    assign added_secs  = clamp_secs({1'b0, rem_q} + ADD_V, MAX_V);
    assign loaded_secs = clamp_secs({1'b0, time_set}, MAX_V);
    assign door_rise   = door_open && !door_q;

    oven_tick_gen #(
        .CLKS_PER_SEC(CLKS_PER_SEC)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (presc_en),
        .clr (presc_clr),
        .tick(sec_tick)
    );

    // Each branch is an if/else-if chain in event priority order.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        beep_cnt_d = beep_cnt_q;
        beep_d     = beep_q;
        presc_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_stop) begin
                    rem_d = '0;
                end else if (btn_start && (rem_q != '0) && !door_open) begin
                    state_d   = ST_COOK;
                    presc_clr = 1'b1;
                end else if (btn_add) begin
                    rem_d = added_secs;
                end else if (time_load) begin
                    rem_d = loaded_secs;
                end
            end
            ST_COOK: begin
                if (btn_stop || door_open) begin
                    state_d = ST_PAUSE;
                end else if (sec_tick) begin
                    if (rem_q <= REM_W'(1)) begin
                        rem_d      = '0;
                        state_d    = ST_DONE;
                        presc_clr  = 1'b1;
                        beep_cnt_d = BEEP_V;
                        beep_d     = (BEEP_SECS != 0);
                    end else begin
                        rem_d = rem_q - 1'b1;
                    end
                end else if (btn_add) begin
                    rem_d = added_secs;
                end
            end
            ST_PAUSE: begin
                if (btn_stop) begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                end else if (btn_start && !door_open) begin
                    state_d = ST_COOK;
                end else if (btn_add) begin
                    rem_d = added_secs;
                end
            end
            ST_DONE: begin
                if (btn_stop || door_rise) begin
                    state_d    = ST_IDLE;
                    beep_cnt_d = '0;
                    beep_d     = 1'b0;
                end else if (sec_tick && (beep_cnt_q != '0)) begin
                    beep_cnt_d = beep_cnt_q - 1'b1;
                    beep_d     = (beep_cnt_q != BEEP_W'(1));
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            beep_cnt_q <= '0;
            beep_q     <= 1'b0;
            heater_q   <= 1'b0;
            door_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            beep_cnt_q <= beep_cnt_d;
            beep_q     <= beep_d;
            heater_q   <= (state_d == ST_COOK);
            door_q     <= door_open;
        end
    end

    assign state     = state_q;
    assign remaining = rem_q;
    assign heater_on = heater_q;
    assign done_beep = beep_q;
    assign tick      = sec_tick;

endmodule

// File: tb/tb_oven_controller.sv
// Scenario bench for oven_controller with a one-second tick of four clocks.
module tb_oven_controller;
    import oven_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] time_set = '0;
    logic       time_load = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_stop = 1'b0;
    logic       btn_add = 1'b0;
    logic       door_open = 1'b0;
    logic [1:0] state;
    logic [9:0] remaining;
    logic       heater_on;
    logic       done_beep;
    logic       tick;

    int n_vec = 0;
    int n_err = 0;
    logic [13:0] exp_q[$];
    logic [13:0] got;
    logic [13:0] exp;

    oven_controller #(
        .CLKS_PER_SEC(4),
        .MAX_SECS    (999),
        .BEEP_SECS   (3),
        .ADD_SECS    (30)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .time_set (time_set),
        .time_load(time_load),
        .btn_start(btn_start),
        .btn_stop (btn_stop),
        .btn_add  (btn_add),
        .door_open(door_open),
        .state    (state),
        .remaining(remaining),
        .heater_on(heater_on),
        .done_beep(done_beep),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- clock/reset and driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; time_load = 0; btn_start = 0; btn_stop = 0; btn_add = 0; door_open = 0;
        step();
        rst = 1'b0;
    endtask

    task automatic load(input logic [9:0] v);
        time_set = v; time_load = 1'b1; step(); time_load = 1'b0;
    endtask

    task automatic pulse_start(); btn_start = 1'b1; step(); btn_start = 1'b0; endtask
    task automatic pulse_stop();  btn_stop  = 1'b1; step(); btn_stop  = 1'b0; endtask
    task automatic pulse_add();   btn_add   = 1'b1; step(); btn_add   = 1'b0; endtask

    task automatic expect_st(input logic [1:0] s, input logic [9:0] r, input logic h, input logic b);
        exp_q.push_back({s, r, h, b});
    endtask

    function automatic logic [13:0] obs();
        return {state, remaining, heater_on, done_beep};
    endfunction

    function automatic string fmt(input logic [13:0] v);
        return $sformatf("st=%0d rem=%0d heat=%0b beep=%0b", v[13:12], v[11:2], v[1], v[0]);
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        expect_st(ST_IDLE, 10'd0, 1'b0, 1'b0);
        do_reset();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL reset_state: got %s want %s", fmt(got), fmt(exp)); end
        n_vec++;
        if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %0b want 0", tick); end
    endtask

    task automatic test_basic_cook();
        do_reset();
        expect_st(ST_IDLE, 10'd3, 1'b0, 1'b0);
        load(10'd3);
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL basic_load: got %s want %s", fmt(got), fmt(exp)); end
        expect_st(ST_COOK, 10'd3, 1'b1, 1'b0);
        pulse_start();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL basic_start: got %s want %s", fmt(got), fmt(exp)); end
        expect_st(ST_COOK, 10'd3, 1'b1, 1'b0);
        repeat (3) step();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL basic_pre_tick: got %s want %s", fmt(got), fmt(exp)); end
        n_vec++;
        if (tick !== 1'b1) begin n_err++; $display("FAIL basic_tick: got %0b want 1", tick); end
        expect_st(ST_COOK, 10'd2, 1'b1, 1'b0);
        step();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL basic_rem2: got %s want %s", fmt(got), fmt(exp)); end
        expect_st(ST_COOK, 10'd1, 1'b1, 1'b0);
        repeat (4) step();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL basic_rem1: got %s want %s", fmt(got), fmt(exp)); end
        expect_st(ST_COOK, 10'd1, 1'b1, 1'b0);
        repeat (3) step();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL basic_cycle11: got %s want %s", fmt(got), fmt(exp)); end
        expect_st(ST_DONE, 10'd0, 1'b0, 1'b1);
        step();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL basic_done: got %s want %s", fmt(got), fmt(exp)); end
        // start, add and load are all ignored in DONE
        expect_st(ST_DONE, 10'd0, 1'b0, 1'b1);
        pulse_start();
        pulse_add();
        load(10'd50);
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL done_ignores: got %s want %s", fmt(got), fmt(exp)); end
        expect_st(ST_DONE, 10'd0, 1'b0, 1'b1);
        repeat (8) step();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL beep_held: got %s want %s", fmt(got), fmt(exp)); end
        expect_st(ST_DONE, 10'd0, 1'b0, 1'b0);
        step();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL beep_drop: got %s want %s", fmt(got), fmt(exp)); end
        expect_st(ST_IDLE, 10'd0, 1'b0, 1'b0);
        pulse_stop();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL done_stop: got %s want %s", fmt(got), fmt(exp)); end
    endtask

    task automatic test_door_interrupt();
        do_reset();
        load(10'd5);
        expect_st(ST_COOK, 10'd5, 1'b1, 1'b0);
        pulse_start();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL door_start: got %s want %s", fmt(got), fmt(exp)); end
        repeat (5) step();
        expect_st(ST_PAUSE, 10'd4, 1'b0, 1'b0);
        door_open = 1'b1;
        step();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL door_pause: got %s want %s", fmt(got), fmt(exp)); end
        door_open = 1'b0;
        step();
        expect_st(ST_COOK, 10'd4, 1'b1, 1'b0);
        pulse_start();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL door_resume: got %s want %s", fmt(got), fmt(exp)); end
        // two prescaler counts were kept from before the pause
        step();
        n_vec++;
        if (tick !== 1'b1) begin n_err++; $display("FAIL door_held_tick: got %0b want 1", tick); end
        expect_st(ST_COOK, 10'd3, 1'b1, 1'b0);
        step();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL door_rem3: got %s want %s", fmt(got), fmt(exp)); end
        expect_st(ST_COOK, 10'd1, 1'b1, 1'b0);
        repeat (11) step();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL door_cycle13: got %s want %s", fmt(got), fmt(exp)); end
        expect_st(ST_DONE, 10'd0, 1'b0, 1'b1);
        step();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL door_done14: got %s want %s", fmt(got), fmt(exp)); end
        expect_st(ST_IDLE, 10'd0, 1'b0, 1'b0);
        door_open = 1'b1;
        step();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL done_door_edge: got %s want %s", fmt(got), fmt(exp)); end
        door_open = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        do_reset();
        expect_st(ST_IDLE, 10'd999, 1'b0, 1'b0);
        load(10'd1000);
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL sat_load: got %s want %s", fmt(got), fmt(exp)); end
        expect_st(ST_IDLE, 10'd999, 1'b0, 1'b0);
        load(10'd980);
        pulse_add();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL sat_add980: got %s want %s", fmt(got), fmt(exp)); end
        expect_st(ST_IDLE, 10'd999, 1'b0, 1'b0);
        load(10'd999);
        pulse_add();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL sat_add999: got %s want %s", fmt(got), fmt(exp)); end
        load(10'd10);
        pulse_start();
        expect_st(ST_COOK, 10'd40, 1'b1, 1'b0);
        pulse_add();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL cook_add: got %s want %s", fmt(got), fmt(exp)); end
        pulse_stop();
        expect_st(ST_PAUSE, 10'd70, 1'b0, 1'b0);
        pulse_add();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL pause_add: got %s want %s", fmt(got), fmt(exp)); end
        expect_st(ST_IDLE, 10'd0, 1'b0, 1'b0);
        pulse_stop();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL pause_stop: got %s want %s", fmt(got), fmt(exp)); end
        expect_st(ST_IDLE, 10'd30, 1'b0, 1'b0);
        pulse_add();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL idle_add0: got %s want %s", fmt(got), fmt(exp)); end
    endtask

    task automatic test_illegal_starts();
        do_reset();
        expect_st(ST_IDLE, 10'd0, 1'b0, 1'b0);
        pulse_start();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL start_zero: got %s want %s", fmt(got), fmt(exp)); end
        load(10'd5);
        door_open = 1'b1;
        expect_st(ST_IDLE, 10'd5, 1'b0, 1'b0);
        pulse_start();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL start_door_idle: got %s want %s", fmt(got), fmt(exp)); end
        door_open = 1'b0;
        pulse_start();
        expect_st(ST_COOK, 10'd5, 1'b1, 1'b0);
        load(10'd9);
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL load_in_cook: got %s want %s", fmt(got), fmt(exp)); end
        door_open = 1'b1;
        step();
        expect_st(ST_PAUSE, 10'd5, 1'b0, 1'b0);
        pulse_start();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL start_door_pause: got %s want %s", fmt(got), fmt(exp)); end
        door_open = 1'b0;
        expect_st(ST_PAUSE, 10'd5, 1'b0, 1'b0);
        load(10'd9);
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL load_in_pause: got %s want %s", fmt(got), fmt(exp)); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        load(10'd5);
        pulse_start();
        repeat (3) step();
        n_vec++;
        if (tick !== 1'b1) begin n_err++; $display("FAIL simul_tick: got %0b want 1", tick); end
        expect_st(ST_PAUSE, 10'd5, 1'b0, 1'b0);
        pulse_stop();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL stop_with_tick: got %s want %s", fmt(got), fmt(exp)); end
        pulse_stop();
        load(10'd6);
        expect_st(ST_IDLE, 10'd0, 1'b0, 1'b0);
        btn_start = 1'b1; btn_stop = 1'b1;
        step();
        btn_start = 1'b0; btn_stop = 1'b0;
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL start_and_stop: got %s want %s", fmt(got), fmt(exp)); end
    endtask

    task automatic test_reset_mid_cook();
        do_reset();
        load(10'd7);
        pulse_start();
        repeat (2) step();
        expect_st(ST_IDLE, 10'd0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL reset_mid_cook: got %s want %s", fmt(got), fmt(exp)); end
        n_vec++;
        if (tick !== 1'b0) begin n_err++; $display("FAIL reset_mid_tick: got %0b want 0", tick); end
        expect_st(ST_IDLE, 10'd0, 1'b0, 1'b0);
        pulse_start();
        got = obs(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL start_after_reset: got %s want %s", fmt(got), fmt(exp)); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        step();
        test_reset();
        test_basic_cook();
        test_door_interrupt();
        test_saturation();
        test_illegal_starts();
        test_simultaneous();
        test_reset_mid_cook();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
